demod_acc: RTL and testbench

DEMOD_ACC -- requirements
Module: demod_acc

---
 rtl/demod_acc_if.sv | 26 ++
 rtl/demod_acc.sv | 183 ++++++++++++++++++
 tb/tb_demod_acc.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/demod_acc_if.sv
// Sample/LO inputs and per-window result bundle for demod_acc.
interface demod_acc_if #(
  parameter int NSLICE = 16,
  parameter int ACCW   = 48,
  parameter int CNTW   = 24
);
  logic                     gatein;
  logic [NSLICE*16-1:0]     adc16xn;
  logic [NSLICE*16-1:0]     lox16xn;
  logic [NSLICE*16-1:0]     loy16xn;
  logic signed [ACCW-1:0]   accx;
  logic signed [ACCW-1:0]   accy;
  logic [CNTW-1:0]          ncyc;
  logic                     ovf;
  logic                     valid;

  modport master (
    output gatein, adc16xn, lox16xn, loy16xn,
    input  accx, accy, ncyc, ovf, valid
  );

  modport slave (
    input  gatein, adc16xn, lox16xn, loy16xn,
    output accx, accy, ncyc, ovf, valid
  );
endinterface

// File: rtl/demod_acc.sv
// I/Q demodulating integrator: multiplies NSLICE ADC samples per clock by the
// conjugate LO, sums them in a registered tree and integrates over a gate window.
module demod_acc #(
  parameter int NSLICE = 16,
  parameter int ACCW   = 48,
  parameter int CNTW   = 24
) (
  input logic        clk,
  input logic        resetn,
  demod_acc_if.slave bus
);

  localparam int LG = $clog2(NSLICE);
  localparam int D  = 3 + LG;
  localparam int TW = 32 + LG;
  localparam int NN = 2 * NSLICE - 1;

  localparam logic signed [ACCW:0] SMAX = {2'b00, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN = -SMAX;

  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

  // Index of the first node of tree level s; leaves are level 0, root is NN-1.
  function automatic int off(input int s);
    return 2 * NSLICE - ((2 * NSLICE) >> s);
  endfunction

  // Reset synchronizer: asserts immediately, releases every flop on one edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together after the edge, regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic signed [15:0] adc_q [NSLICE];
  logic signed [15:0] lox_q [NSLICE];
  logic signed [15:0] loy_q [NSLICE];
  logic signed [31:0] px1   [NSLICE];
  logic signed [31:0] py1   [NSLICE];
  logic signed [TW-1:0] tx  [NN];
  logic signed [TW-1:0] ty  [NN];
  logic [D-1:0]       gate_pipe;
  logic               dgate;
  logic signed [TW-1:0] sum_x, sum_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are pipeline flops, not a RAM, so they are cleared
      // in reset like any other register; a real memory would not be.
      for (int i = 0; i < NSLICE; i++) begin
        adc_q[i] <= '0;
        lox_q[i] <= '0;
        loy_q[i] <= '0;
        px1[i]   <= '0;
        py1[i]   <= '0;
      end
      for (int k = 0; k < NN; k++) begin
        tx[k] <= '0;
        ty[k] <= '0;
      end
      gate_pipe <= '0;
    end else begin
      gate_pipe <= {gate_pipe[D-2:0], bus.gatein};
      for (int i = 0; i < NSLICE; i++) begin
        adc_q[i] <= bus.adc16xn[16*i +: 16];
        lox_q[i] <= bus.lox16xn[16*i +: 16];
        loy_q[i] <= bus.loy16xn[16*i +: 16];
        px1[i]   <= 32'(adc_q[i]) * 32'(lox_q[i]);
        py1[i]   <= 32'(adc_q[i]) * 32'(loy_q[i]);
        // Second multiplier stage applies the conjugate sign and widens.
        tx[i]    <= TW'(px1[i]);
        ty[i]    <= -TW'(py1[i]);
      end
      for (int s = 1; s <= LG; s++) begin
        for (int j = 0; j < (NSLICE >> s); j++) begin
          tx[off(s) + j] <= tx[off(s-1) + 2*j] + tx[off(s-1) + 2*j + 1];
          ty[off(s) + j] <= ty[off(s-1) + 2*j] + ty[off(s-1) + 2*j + 1];
        end
      end
    end
  end

  assign dgate = gate_pipe[D-1];
  assign sum_x = tx[NN-1];
  assign sum_y = ty[NN-1];

  state_t                 state;
  logic signed [ACCW-1:0] acc_x, acc_y;
  logic [CNTW-1:0]        cnt;
  logic                   ovf_s;
  logic signed [ACCW-1:0] accx_q, accy_q;
  logic [CNTW-1:0]        ncyc_q;
  logic                   ovf_q, valid_q;

  logic signed [ACCW:0]   nx, ny;
  logic signed [ACCW-1:0] sat_x, sat_y;
  logic                   clip_x, clip_y;
  logic [CNTW-1:0]        cnt_inc;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    nx     = (ACCW+1)'(acc_x) + (ACCW+1)'(sum_x);
    ny     = (ACCW+1)'(acc_y) + (ACCW+1)'(sum_y);
    sat_x  = ACCW'(nx);
    sat_y  = ACCW'(ny);
    clip_x = 1'b0;
    clip_y = 1'b0;
    if (nx > SMAX) begin sat_x = ACCW'(SMAX); clip_x = 1'b1; end
    if (nx < SMIN) begin sat_x = ACCW'(SMIN); clip_x = 1'b1; end
    if (ny > SMAX) begin sat_y = ACCW'(SMAX); clip_y = 1'b1; end
    if (ny < SMIN) begin sat_y = ACCW'(SMIN); clip_y = 1'b1; end
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_x   <= '0;
      acc_y   <= '0;
      cnt     <= '0;
      ovf_s   <= 1'b0;
      accx_q  <= '0;
      accy_q  <= '0;
      ncyc_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dgate) begin
            acc_x <= ACCW'(sum_x);
            acc_y <= ACCW'(sum_y);
            cnt   <= CNTW'(1);
            ovf_s <= 1'b0;
            state <= ACC;
          end
        end
        ACC: begin
          if (dgate) begin
            acc_x <= sat_x;
            acc_y <= sat_y;
            cnt   <= cnt_inc;
            ovf_s <= ovf_s | clip_x | clip_y;
          end else begin
            accx_q <= acc_x;
            accy_q <= acc_y;
            ncyc_q <= cnt;
            ovf_q  <= ovf_s;
            state  <= DUMP;
          end
        end
        DUMP: begin
          valid_q <= 1'b1;
          if (dgate) begin
            acc_x <= ACCW'(sum_x);
            acc_y <= ACCW'(sum_y);
            cnt   <= CNTW'(1);
            ovf_s <= 1'b0;
            state <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.accx  = accx_q;
  assign bus.accy  = accy_q;
  assign bus.ncyc  = ncyc_q;
  assign bus.ovf   = ovf_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_demod_acc.sv
// Bench for demod_acc: table of fixed windows, hand-built corner sequences and
// a random regression, all checked through an expected-result queue.
module tb_demod_acc;

  localparam int NSLICE = 16;
  localparam int ACCW   = 40;
  localparam int CNTW   = 24;
  localparam int D      = 3 + $clog2(NSLICE);
  localparam int VW     = NSLICE * 16;
  localparam longint SMAX = (64'sd1 <<< (ACCW - 1)) - 64'sd1;

  typedef struct {
    int          len;
    logic [15:0] a, x, y;
    longint      ex, ey;
    int          en;
    bit          eo;
  } vec_t;

  typedef struct {
    longint ex, ey;
    int     en;
    bit     eo;
    int     ecyc;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];
  vec_t tbl[7];

  demod_acc_if #(.NSLICE(NSLICE), .ACCW(ACCW), .CNTW(CNTW)) dif ();

  demod_acc #(.NSLICE(NSLICE), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Result monitor: every valid strobe must match the oldest expected window.
  always @(negedge clk) begin : mon
    exp_t e;
    if (dif.valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("accx", dif.accx, e.ex);
        check("accy", dif.accy, e.ey);
        check("ncyc", dif.ncyc, e.en);
        check("ovf", dif.ovf, e.eo);
        check("valid_cycle", cyc, e.ecyc);
      end
    end
  end

  task automatic drive(input logic g, input logic [VW-1:0] a, x, y);
    @(posedge clk);
    #1;
    dif.gatein  = g;
    dif.adc16xn = a;
    dif.lox16xn = x;
    dif.loy16xn = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  task automatic run_window(input int n, input logic [15:0] a, x, y,
                            input longint ex, ey, input int en, input bit eo);
    for (int i = 0; i < n; i++) drive(1'b1, {NSLICE{a}}, {NSLICE{x}}, {NSLICE{y}});
    drive(1'b0, '0, '0, '0);
    sb.push_back(exp_t'{ex, ey, en, eo, cyc + D + 2});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_accx"}, dif.accx, 0);
    check({tag, "_accy"}, dif.accy, 0);
    check({tag, "_ncyc"}, dif.ncyc, 0);
    check({tag, "_ovf"}, dif.ovf, 0);
    check({tag, "_valid"}, dif.valid, 0);
  endtask

  function automatic longint clamp(input longint v);
    if (v > SMAX)  return SMAX;
    if (v < -SMAX) return -SMAX;
    return v;
  endfunction

  initial begin
    logic [VW-1:0] ra, rx, ry;
    logic          g;
    bit            in_win;
    longint        mx, my, sx, sy;
    int            mn;
    bit            mo;

    n_chk  = 0;
    n_fail = 0;

    tbl[0] = vec_t'{10, 16'h4000, 16'h7fff, 16'h0000, 64'sd85896724480, 64'sd0, 10, 1'b0};
    tbl[1] = vec_t'{1,  16'hc000, 16'h0000, 16'h7fff, 64'sd0, 64'sd8589672448, 1, 1'b0};
    tbl[2] = vec_t'{1,  16'h8000, 16'h0000, 16'h7fff, 64'sd0, 64'sd17179344896, 1, 1'b0};
    tbl[3] = vec_t'{40, 16'h7fff, 16'h7fff, 16'h0000, 64'sd549755813887, 64'sd0, 40, 1'b1};
    tbl[4] = vec_t'{3,  16'h7fff, 16'h7fff, 16'h0000, 64'sd51536461872, 64'sd0, 3, 1'b0};
    tbl[5] = vec_t'{40, 16'h8000, 16'h7fff, 16'h7fff, -64'sd549755813887, 64'sd549755813887, 40, 1'b1};
    tbl[6] = vec_t'{2,  16'h1234, 16'h2000, 16'he000, 64'sd1221591040, 64'sd1221591040, 2, 1'b0};

    resetn      = 1'b0;
    dif.gatein  = 1'b0;
    dif.adc16xn = '0;
    dif.lox16xn = '0;
    dif.loy16xn = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(4);

    for (int t = 0; t < 7; t++) begin
      run_window(tbl[t].len, tbl[t].a, tbl[t].x, tbl[t].y,
                 tbl[t].ex, tbl[t].ey, tbl[t].en, tbl[t].eo);
      idle(3);
    end
    wait_drain();

    // Two 5-cycle windows with a single low cycle between them.
    run_window(5, 16'h4000, 16'h7fff, 16'h0000, 64'sd42948362240, 64'sd0, 5, 1'b0);
    run_window(5, 16'h4000, 16'h7fff, 16'h0000, 64'sd42948362240, 64'sd0, 5, 1'b0);
    wait_drain();

    // Reset pulse in the middle of an 8-cycle window discards the window.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {NSLICE{16'h4000}}, {NSLICE{16'h7fff}}, '0);
      if (i == 3) resetn = 1'b0;
      if (i == 6) resetn = 1'b1;
      if (i == 4) begin
        @(negedge clk);
        check_outputs_zero("in_reset");
      end
    end
    idle(D + 6);
    check_outputs_zero("after_reset");

    run_window(4, 16'h4000, 16'h7fff, 16'h0000, 64'sd34358689792, 64'sd0, 4, 1'b0);
    wait_drain();

    // Random regression against an arithmetic window model.
    in_win = 1'b0;
    mx = 0; my = 0; mn = 0; mo = 1'b0;
    for (int c = 0; c < 600; c++) begin
      g = in_win ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NSLICE; i++) begin
        ra[16*i +: 16] = 16'($urandom);
        rx[16*i +: 16] = 16'($urandom);
        ry[16*i +: 16] = 16'($urandom);
      end
      drive(g, ra, rx, ry);
      sx = 0;
      sy = 0;
      for (int i = 0; i < NSLICE; i++) begin
        sx += longint'($signed(ra[16*i +: 16])) * longint'($signed(rx[16*i +: 16]));
        sy -= longint'($signed(ra[16*i +: 16])) * longint'($signed(ry[16*i +: 16]));
      end
      if (g) begin
        if (!in_win) begin
          mx = sx; my = sy; mn = 1; mo = 1'b0; in_win = 1'b1;
        end else begin
          if (clamp(mx + sx) != mx + sx || clamp(my + sy) != my + sy) mo = 1'b1;
          mx = clamp(mx + sx);
          my = clamp(my + sy);
          mn++;
        end
      end else if (in_win) begin
        sb.push_back(exp_t'{mx, my, mn, mo, cyc + D + 2});
        in_win = 1'b0;
      end
    end
    if (in_win) begin
      drive(1'b0, '0, '0, '0);
      sb.push_back(exp_t'{mx, my, mn, mo, cyc + D + 2});
    end
    idle(2);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
